// File: rtl/ysyx_23060077_lsu_align_if.sv
// LSU-side AXI-lite style bus bundle between ysyx_23060077_lsu_align and the bus arbiter.
// The LSU drives the master modport and the arbiter or memory model drives the slave modport.
interface ysyx_23060077_lsu_align_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3
);
    logic                    lsu_r_valid_o;
    logic [ADDR_WIDTH-1:0]   lsu_r_addr_o;
    logic [SIZE_WIDTH-1:0]   lsu_r_size_o;
    logic [LEN_WIDTH-1:0]    lsu_r_len_o;
    logic                    lsu_r_ready_i;
    logic [DATA_WIDTH-1:0]   lsu_r_data_i;
    logic                    lsu_r_last_i;

    logic                    lsu_w_valid_o;
    logic [ADDR_WIDTH-1:0]   lsu_w_addr_o;
    logic [DATA_WIDTH-1:0]   lsu_w_data_o;
    logic [DATA_WIDTH/8-1:0] lsu_w_strb_o;
    logic [SIZE_WIDTH-1:0]   lsu_w_size_o;
    logic [LEN_WIDTH-1:0]    lsu_w_len_o;
    logic                    lsu_w_ready_i;
    logic                    lsu_w_last_i;

    modport master (
        output lsu_r_valid_o, lsu_r_addr_o, lsu_r_size_o, lsu_r_len_o,
        input  lsu_r_ready_i, lsu_r_data_i, lsu_r_last_i,
        output lsu_w_valid_o, lsu_w_addr_o, lsu_w_data_o, lsu_w_strb_o,
        output lsu_w_size_o, lsu_w_len_o,
        input  lsu_w_ready_i, lsu_w_last_i
    );

    modport slave (
        input  lsu_r_valid_o, lsu_r_addr_o, lsu_r_size_o, lsu_r_len_o,
        output lsu_r_ready_i, lsu_r_data_i, lsu_r_last_i,
        input  lsu_w_valid_o, lsu_w_addr_o, lsu_w_data_o, lsu_w_strb_o,
        input  lsu_w_size_o, lsu_w_len_o,
        output lsu_w_ready_i, lsu_w_last_i
    );
endinterface

// File: rtl/ysyx_23060077_lsu_align.sv
// Load/store unit with byte-lane alignment, load sign/zero extension and misalign detection.
// It uses a registered IDLE/RD/WR/RESP FSM, and every access retires through exactly one RESP cycle.
module ysyx_23060077_lsu_align #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3,
    parameter int OPT_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [OPT_WIDTH-1:0]  lsu_opt,
    input  logic [2:0]            funct3,
    input  logic                  ifu_stall,
    ysyx_23060077_lsu_align_if.master lsu_bus,
    output logic                  mem_stall,
    output logic                  lsu_rd_wen,
    output logic [DATA_WIDTH-1:0] lsu_result,
    output logic                  lsu_misalign,
    output logic [ADDR_WIDTH-1:0] lsu_bad_addr
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [OPT_WIDTH-1:0] OPT_LOAD  = OPT_WIDTH'(1);
    localparam logic [OPT_WIDTH-1:0] OPT_STORE = OPT_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] ea_q,       ea_d;
    logic [2:0]            funct3_q,   funct3_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [STRB_W-1:0]     strb_q,     strb_d;
    logic                  fault_q,    fault_d;
    logic [DATA_WIDTH-1:0] result_q,   result_d;
    logic [ADDR_WIDTH-1:0] bad_addr_q, bad_addr_d;

    logic [DATA_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] ea;
    logic [OFF_W-1:0]      off;
    logic [OFF_W-1:0]      lane_off;
    logic                  is_load, is_store, start;
    logic                  misaligned, illegal;
    logic [STRB_W-1:0]     strb_base;
    logic [DATA_WIDTH-1:0] raw, load_ext;

    assign sum      = src1 + imm;
    assign ea       = sum[ADDR_WIDTH-1:0];
    assign off      = ea[OFF_W-1:0];
    assign lane_off = ea_q[OFF_W-1:0];
    assign is_load  = (lsu_opt == OPT_LOAD);
    assign is_store = (lsu_opt == OPT_STORE);
    // Reset gates start so that mem_stall also reads 0 while reset is held low.
    assign start    = (is_load || is_store) && !ifu_stall && reset;

    assign illegal = (funct3 == 3'b111)
                  || (((funct3 == 3'b011) || (funct3 == 3'b110)) && (DATA_WIDTH == 32))
                  || (is_store && funct3[2]);

    // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        misaligned = 1'b0;
        strb_base  = '0;
        unique case (funct3[1:0])
            2'd0: begin misaligned = 1'b0;      strb_base = STRB_W'(1);    end
            2'd1: begin misaligned = ea[0];     strb_base = STRB_W'(3);    end
            2'd2: begin misaligned = |ea[1:0];  strb_base = STRB_W'(4'hF); end
            default: begin misaligned = |ea[2:0]; strb_base = {STRB_W{1'b1}}; end
        endcase
    end

    assign raw = lsu_bus.lsu_r_data_i >> {lane_off, 3'b000};

    always_comb begin
        load_ext = raw;
        unique case (funct3_q)
            3'b000:  load_ext = DATA_WIDTH'($signed(raw[7:0]));
            3'b001:  load_ext = DATA_WIDTH'($signed(raw[15:0]));
            3'b010:  load_ext = DATA_WIDTH'($signed(raw[31:0]));
            3'b100:  load_ext = DATA_WIDTH'(raw[7:0]);
            3'b101:  load_ext = DATA_WIDTH'(raw[15:0]);
            3'b110:  load_ext = DATA_WIDTH'(raw[31:0]);
            default: load_ext = raw;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ea_d       = ea_q;
        funct3_d   = funct3_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        fault_d    = fault_q;
        result_d   = result_q;
        bad_addr_d = bad_addr_q;
        mem_stall  = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_stall = start;
                if (start) begin
                    ea_d     = ea;
                    funct3_d = funct3;
                    wdata_d  = src2 << {off, 3'b000};
                    strb_d   = strb_base << off;
                    fault_d  = misaligned || illegal;
                    if (misaligned || illegal) begin
                        bad_addr_d = ea;
                        state_d    = RESP;
                    end else begin
                        state_d = is_load ? RD : WR;
                    end
                end
            end
            RD: begin
                mem_stall = 1'b1;
                if (lsu_bus.lsu_r_ready_i && lsu_bus.lsu_r_last_i) begin
                    result_d = load_ext;
                    state_d  = RESP;
                end
            end
            WR: begin
                mem_stall = 1'b1;
                if (lsu_bus.lsu_w_ready_i && lsu_bus.lsu_w_last_i) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ea_q       <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            fault_q    <= 1'b0;
            result_q   <= '0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ea_q       <= ea_d;
            funct3_q   <= funct3_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            fault_q    <= fault_d;
            result_q   <= result_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    assign lsu_bus.lsu_r_valid_o = (state_q == RD);
    assign lsu_bus.lsu_r_addr_o  = {ea_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
    assign lsu_bus.lsu_r_size_o  = SIZE_WIDTH'(funct3_q[1:0]);
    assign lsu_bus.lsu_r_len_o   = '0;
    assign lsu_bus.lsu_w_valid_o = (state_q == WR);
    assign lsu_bus.lsu_w_addr_o  = {ea_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
    assign lsu_bus.lsu_w_data_o  = wdata_q;
    assign lsu_bus.lsu_w_strb_o  = strb_q;
    assign lsu_bus.lsu_w_size_o  = SIZE_WIDTH'(funct3_q[1:0]);
    assign lsu_bus.lsu_w_len_o   = '0;

    assign lsu_rd_wen   = (state_q == RESP) && !fault_q;
    assign lsu_misalign = (state_q == RESP) && fault_q;
    assign lsu_result   = result_q;
    assign lsu_bad_addr = bad_addr_q;
endmodule

// File: tb/tb_ysyx_23060077_lsu_align.sv
// Directed bench for ysyx_23060077_lsu_align (64-bit data), with expected values worked out by hand.
// Inputs change one time unit after posedge and are checked after a further settle delay.
module tb_ysyx_23060077_lsu_align;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam logic [1:0] LD = 2'd1;
    localparam logic [1:0] ST = 2'd2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] src1, src2, imm;
    logic [1:0]    lsu_opt;
    logic [2:0]    funct3;
    logic          ifu_stall;
    logic          mem_stall, lsu_rd_wen, lsu_misalign;
    logic [DW-1:0] lsu_result;
    logic [AW-1:0] lsu_bad_addr;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060077_lsu_align_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(8), .SIZE_WIDTH(3)) bus ();

    ysyx_23060077_lsu_align #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .src1         (src1),
        .src2         (src2),
        .imm          (imm),
        .lsu_opt      (lsu_opt),
        .funct3       (funct3),
        .ifu_stall    (ifu_stall),
        .lsu_bus      (bus),
        .mem_stall    (mem_stall),
        .lsu_rd_wen   (lsu_rd_wen),
        .lsu_result   (lsu_result),
        .lsu_misalign (lsu_misalign),
        .lsu_bad_addr (lsu_bad_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] opt, input logic [63:0] s1, input logic [63:0] s2,
                         input logic [63:0] im, input logic [2:0] f3);
        lsu_opt = opt;
        src1    = s1;
        src2    = s2;
        imm     = im;
        funct3  = f3;
    endtask

    task automatic rd_resp(input logic ready, input logic last, input logic [63:0] data);
        bus.lsu_r_ready_i = ready;
        bus.lsu_r_last_i  = last;
        bus.lsu_r_data_i  = data;
    endtask

    task automatic wr_resp(input logic ready, input logic last);
        bus.lsu_w_ready_i = ready;
        bus.lsu_w_last_i  = last;
    endtask

    // A load that returns data on its first RD cycle; the result is checked in RESP.
    task automatic quick_load(input string tag, input logic [2:0] f3, input logic [63:0] im,
                              input logic [63:0] data, input logic [63:0] exp_addr,
                              input logic [63:0] exp_res);
        issue(LD, 64'h8000_0000, 64'h0, im, f3);
        tick();
        lsu_opt = 2'd0;
        rd_resp(1'b1, 1'b1, data);
        #1;
        check({tag, "_raddr"}, bus.lsu_r_addr_o, exp_addr);
        tick();
        rd_resp(1'b0, 1'b0, 64'h0);
        #1;
        check({tag, "_wen"}, lsu_rd_wen, 1'b1);
        check({tag, "_res"}, lsu_result, exp_res);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        issue(LD, 64'h8000_0000, 64'h0, 64'h4, 3'b010);
        ifu_stall = 1'b0;
        rd_resp(1'b0, 1'b0, 64'h0);
        wr_resp(1'b0, 1'b0);
        #3;
        check("rst_stall",   mem_stall, 1'b0);
        check("rst_rvalid",  bus.lsu_r_valid_o, 1'b0);
        check("rst_wvalid",  bus.lsu_w_valid_o, 1'b0);
        check("rst_wen",     lsu_rd_wen, 1'b0);
        check("rst_mis",     lsu_misalign, 1'b0);
        check("rst_result",  lsu_result, 64'h0);
        check("rst_badaddr", lsu_bad_addr, 32'h0);
        check("rst_strb",    bus.lsu_w_strb_o, 8'h00);
        lsu_opt = 2'd0;
        tick();
        reset = 1'b1;
        tick();

        // lw at offset 4 with ready one cycle after valid
        issue(LD, 64'h8000_0000, 64'h0, 64'h4, 3'b010);
        #1;
        check("t1_start_stall", mem_stall, 1'b1);
        check("t1_start_rvalid", bus.lsu_r_valid_o, 1'b0);
        tick();
        lsu_opt = 2'd0;
        #1;
        check("t1_rvalid", bus.lsu_r_valid_o, 1'b1);
        check("t1_raddr",  bus.lsu_r_addr_o, 32'h8000_0000);
        check("t1_rsize",  bus.lsu_r_size_o, 3'd2);
        check("t1_rlen",   bus.lsu_r_len_o, 8'd0);
        check("t1_stall",  mem_stall, 1'b1);
        tick();
        rd_resp(1'b1, 1'b1, 64'h8765_4321_0000_0000);
        #1;
        check("t1_rvalid2", bus.lsu_r_valid_o, 1'b1);
        tick();
        rd_resp(1'b0, 1'b0, 64'h0);
        #1;
        check("t1_wen",    lsu_rd_wen, 1'b1);
        check("t1_result", lsu_result, 64'hFFFF_FFFF_8765_4321);
        check("t1_stall_resp", mem_stall, 1'b0);
        check("t1_rvalid_resp", bus.lsu_r_valid_o, 1'b0);
        tick();
        check("t1_wen_off", lsu_rd_wen, 1'b0);
        check("t1_held",    lsu_result, 64'hFFFF_FFFF_8765_4321);

        // a bus response arriving while IDLE must be ignored
        rd_resp(1'b1, 1'b1, 64'h1111_2222_3333_4444);
        tick();
        rd_resp(1'b0, 1'b0, 64'h0);
        #1;
        check("idle_ignore_res", lsu_result, 64'hFFFF_FFFF_8765_4321);
        check("idle_ignore_wen", lsu_rd_wen, 1'b0);

        // lbu / lb from lane 7, then ld, lhu and lwu
        quick_load("lbu", 3'b100, 64'h7, 64'h8000_0000_0000_0000, 32'h8000_0000, 64'h80);
        quick_load("lb",  3'b000, 64'h7, 64'h8000_0000_0000_0000, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        quick_load("ld",  3'b011, 64'h8, 64'h1122_3344_5566_7788, 32'h8000_0008, 64'h1122_3344_5566_7788);
        quick_load("lhu", 3'b101, 64'h6, 64'hBEEF_0000_0000_0000, 32'h8000_0000, 64'hBEEF);
        quick_load("lwu", 3'b110, 64'h4, 64'h8765_4321_0000_0000, 32'h8000_0000, 64'h8765_4321);

        // lh where ready arrives once without last
        issue(LD, 64'h8000_0000, 64'h0, 64'h2, 3'b001);
        tick();
        lsu_opt = 2'd0;
        rd_resp(1'b1, 1'b0, 64'hDEAD_DEAD_DEAD_DEAD);
        tick();
        #1;
        check("lh_nolast_rvalid", bus.lsu_r_valid_o, 1'b1);
        check("lh_nolast_wen",    lsu_rd_wen, 1'b0);
        rd_resp(1'b1, 1'b1, 64'h0000_0000_8001_0000);
        tick();
        rd_resp(1'b0, 1'b0, 64'h0);
        #1;
        check("lh_wen", lsu_rd_wen, 1'b1);
        check("lh_res", lsu_result, 64'hFFFF_FFFF_FFFF_8001);
        tick();

        // sh to offset 6; src2 changes during WR must not leak through
        issue(ST, 64'h8000_0000, 64'hABCD, 64'h6, 3'b001);
        #1;
        check("sh_start_stall", mem_stall, 1'b1);
        tick();
        issue(2'd0, 64'h0, 64'hFFFF, 64'h0, 3'b000);
        #1;
        check("sh_wvalid", bus.lsu_w_valid_o, 1'b1);
        check("sh_rvalid", bus.lsu_r_valid_o, 1'b0);
        check("sh_waddr",  bus.lsu_w_addr_o, 32'h8000_0000);
        check("sh_strb",   bus.lsu_w_strb_o, 8'hC0);
        check("sh_wdata",  bus.lsu_w_data_o, 64'hABCD_0000_0000_0000);
        check("sh_wsize",  bus.lsu_w_size_o, 3'd1);
        check("sh_wlen",   bus.lsu_w_len_o, 8'd0);
        tick();
        check("sh_stall_wait", mem_stall, 1'b1);
        wr_resp(1'b1, 1'b0);
        tick();
        check("sh_stall_nolast", mem_stall, 1'b1);
        wr_resp(1'b1, 1'b1);
        tick();
        wr_resp(1'b0, 1'b0);
        #1;
        check("sh_wen",    lsu_rd_wen, 1'b1);
        check("sh_stall",  mem_stall, 1'b0);
        check("sh_wvalid_resp", bus.lsu_w_valid_o, 1'b0);
        check("sh_result_held", lsu_result, 64'hFFFF_FFFF_FFFF_8001);
        tick();
        check("sh_wen_off", lsu_rd_wen, 1'b0);

        // sw to offset 4 with an immediate write acceptance
        issue(ST, 64'h8000_0000, 64'h1234_5678, 64'h4, 3'b010);
        tick();
        lsu_opt = 2'd0;
        #1;
        check("sw_strb",  bus.lsu_w_strb_o, 8'hF0);
        check("sw_wdata", bus.lsu_w_data_o, 64'h1234_5678_0000_0000);
        wr_resp(1'b1, 1'b1);
        tick();
        wr_resp(1'b0, 1'b0);
        #1;
        check("sw_wen", lsu_rd_wen, 1'b1);
        tick();

        // misaligned lw: fault pulse and no bus request
        issue(LD, 64'h8000_0000, 64'h0, 64'h2, 3'b010);
        #1;
        check("mis_start_stall", mem_stall, 1'b1);
        tick();
        lsu_opt = 2'd0;
        #1;
        check("mis_rvalid",  bus.lsu_r_valid_o, 1'b0);
        check("mis_pulse",   lsu_misalign, 1'b1);
        check("mis_wen",     lsu_rd_wen, 1'b0);
        check("mis_badaddr", lsu_bad_addr, 32'h8000_0002);
        check("mis_result",  lsu_result, 64'hFFFF_FFFF_FFFF_8001);
        tick();
        check("mis_pulse_off", lsu_misalign, 1'b0);
        check("mis_rvalid_off", bus.lsu_r_valid_o, 1'b0);
        check("mis_badaddr_held", lsu_bad_addr, 32'h8000_0002);

        // a store with funct3[2] set is illegal even when aligned
        issue(ST, 64'h8000_0000, 64'h55, 64'h10, 3'b100);
        tick();
        lsu_opt = 2'd0;
        #1;
        check("ill_wvalid",  bus.lsu_w_valid_o, 1'b0);
        check("ill_pulse",   lsu_misalign, 1'b1);
        check("ill_badaddr", lsu_bad_addr, 32'h8000_0010);
        tick();

        // ifu_stall holds the launch, then ready is delayed five cycles
        ifu_stall = 1'b1;
        issue(LD, 64'h8000_0000, 64'h0, 64'h10, 3'b011);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ifu_rvalid", bus.lsu_r_valid_o, 1'b0);
            check("ifu_stall",  mem_stall, 1'b0);
            tick();
        end
        ifu_stall = 1'b0;
        #1;
        check("ifu_launch_stall", mem_stall, 1'b1);
        tick();
        issue(2'd0, 64'h4000_0000, 64'h0, 64'h0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("dly_stall", mem_stall, 1'b1);
            check("dly_raddr", bus.lsu_r_addr_o, 32'h8000_0010);
            check("dly_wen",   lsu_rd_wen, 1'b0);
            tick();
        end
        rd_resp(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF);
        tick();
        rd_resp(1'b0, 1'b0, 64'h0);
        #1;
        check("dly_done_wen", lsu_rd_wen, 1'b1);
        check("dly_result",   lsu_result, 64'h0123_4567_89AB_CDEF);
        tick();

        // reset in the second RD cycle drops valid and stall immediately
        issue(LD, 64'h8000_0000, 64'h0, 64'h0, 3'b011);
        tick();
        lsu_opt = 2'd0;
        tick();
        #1;
        check("rst_mid_rvalid_pre", bus.lsu_r_valid_o, 1'b1);
        reset = 1'b0;
        rd_resp(1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000);
        #1;
        check("rst_mid_rvalid", bus.lsu_r_valid_o, 1'b0);
        check("rst_mid_stall",  mem_stall, 1'b0);
        check("rst_mid_result", lsu_result, 64'h0);
        tick();
        rd_resp(1'b0, 1'b0, 64'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_post_wen",    lsu_rd_wen, 1'b0);
            check("rst_post_rvalid", bus.lsu_r_valid_o, 1'b0);
            check("rst_post_stall",  mem_stall, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ysyx_23060077_lsu_align.md
Name: ysyx_23060077_lsu_align

Overview:
Parametrised load/store unit for the ysyx_23060077 core. It replaces the single-size, lane-0-only LSU with a registered FSM that:
- computes and captures the effective address;
- generates byte-lane-aligned bus addresses, shifted write data and write strobes;
- extracts and sign/zero-extends load data from any byte lane;
- detects misaligned accesses without issuing a bus transaction.

It sits between the EXU and the AXI-lite style LSU master port of the core's bus arbiter.

Parameters:
DATA_WIDTH, 64, register and bus data width; 32 or 64 only.
ADDR_WIDTH, 32, bus address width.
LEN_WIDTH, 8, burst length field width.
SIZE_WIDTH, 3, transfer size field width.
OPT_WIDTH, 2, lsu_opt width; OPT_LOAD=2'd1, OPT_STORE=2'd2, all other codes = no operation.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
src1  in  DATA_WIDTH  base register
src2  in  DATA_WIDTH  store data
imm  in  DATA_WIDTH  sign-extended offset
lsu_opt  in  OPT_WIDTH  operation
funct3  in  3  RISC-V width/sign code
ifu_stall  in  1  blocks request launch while high
lsu_r_valid_o  out  1  read request valid
lsu_r_addr_o  out  ADDR_WIDTH  lane-aligned read address
lsu_r_size_o  out  SIZE_WIDTH  log2 bytes
lsu_r_len_o  out  LEN_WIDTH  always 0
lsu_r_ready_i  in  1  read data valid
lsu_r_data_i  in  DATA_WIDTH  full bus beat
lsu_r_last_i  in  1  last beat
lsu_w_valid_o  out  1  write request valid
lsu_w_addr_o  out  ADDR_WIDTH  lane-aligned write address
lsu_w_data_o  out  DATA_WIDTH  lane-shifted data
lsu_w_strb_o  out  DATA_WIDTH/8  byte strobes
lsu_w_size_o  out  SIZE_WIDTH  log2 bytes
lsu_w_len_o  out  LEN_WIDTH  always 0
lsu_w_ready_i  in  1  write accepted
lsu_w_last_i  in  1  last beat
mem_stall  out  1  hold pipeline
lsu_rd_wen  out  1  one-cycle completion pulse
lsu_result  out  DATA_WIDTH  extended load data, held
lsu_misalign  out  1  one-cycle misalign/illegal pulse
lsu_bad_addr  out  ADDR_WIDTH  faulting address, held

Behaviour:
Reset and state:
- reset low: state=IDLE; every output and internal register is 0 immediately, asynchronously.
- States: IDLE, RD, WR, RESP.

Address and alignment arithmetic:
- ea = (src1+imm)[ADDR_WIDTH-1:0].
- off = ea[log2(DATA_WIDTH/8)-1:0].
- Bus address = ea with the off bits cleared.
- size = funct3[1:0].
- Misaligned when (ea mod 2^size) != 0.
- Illegal when any of:
  - funct3 = 3'b111;
  - funct3 = 3'b011 or 3'b110 with DATA_WIDTH=32;
  - a store with funct3[2]=1.

IDLE: start = (lsu_opt is LOAD or STORE) and ifu_stall=0.
- mem_stall = start, combinationally.
- On start, register ea, off, funct3, shifted store data and strobes, then:
  - misaligned or illegal: go to RESP with fault flag set; lsu_bad_addr <= ea; no bus valid asserted;
  - load: go to RD;
  - store: go to WR.
- Bus responses arriving in IDLE are ignored.

RD:
- lsu_r_valid_o=1; address and size come from registers and are stable until done.
- When lsu_r_ready_i & lsu_r_last_i:
  - raw = lsu_r_data_i >> (off*8);
  - lsu_result <= extend(raw):
    - 000 = 8-bit sign-extend;
    - 001 = 16-bit sign-extend;
    - 010 = 32-bit sign-extend;
    - 011 = 64-bit;
    - 100/101/110 = zero-extend;
  - go to RESP.
- ready without last: stay in RD.

WR:
- lsu_w_valid_o=1.
- lsu_w_data_o = src2 << (off*8).
- lsu_w_strb_o = ((1<<(1<<size))-1) << off.
- When lsu_w_ready_i & lsu_w_last_i: go to RESP; lsu_result is unchanged.

RESP (exactly one cycle, then IDLE):
- mem_stall=0.
- No fault: lsu_rd_wen=1.
- Fault: lsu_misalign=1, lsu_rd_wen=0, lsu_result unchanged.
- RESP never starts a new request; the instruction retires at the end of RESP.

Other rules:
- mem_stall=1 throughout RD and WR.
- Latency: a load with ready on the first RD cycle has lsu_rd_wen exactly 2 cycles after the start cycle.
- Changes on src1, src2, imm or funct3 during RD/WR have no effect.
- Reset asserted mid-transaction drops valid immediately; no completion pulse follows.

Test Plan:
1. DATA_WIDTH=64, LOAD funct3=010, ea=0x8000_0004, r_data=0x8765_4321_0000_0000, ready one cycle after valid -> r_addr=0x8000_0000, size=2, lsu_result=0xFFFF_FFFF_8765_4321, lsu_rd_wen one cycle.
2. LOAD funct3=100 vs 000, ea offset 7, r_data[63:56]=0x80 -> lbu gives 0x80; lb gives 0xFFFF_FFFF_FFFF_FF80.
3. STORE funct3=001, ea=0x8000_0006, src2=0xABCD -> w_addr=0x8000_0000, strb=0xC0, data[63:48]=0xABCD, size=1; mem_stall held until ready&last; then one RESP cycle.
4. LOAD funct3=010 with ea=0x8000_0002 -> no r_valid ever, lsu_misalign pulse, lsu_bad_addr=0x8000_0002, lsu_rd_wen=0.
5. LOAD with ifu_stall=1 for 3 cycles -> no r_valid, mem_stall=0; then launch when ifu_stall drops; lsu_r_ready_i delayed 5 cycles -> mem_stall high for all of them, address stable.
6. Reset low in RD cycle 2 -> r_valid and mem_stall 0 immediately, state IDLE, no lsu_rd_wen after release.
